m6809_uart: RTL

Memory-mapped 8N1 UART peripheral on the m6809 SoC data bus, decoded by the integration layer at page $FE (address[15:8] == 8'hFE) alongside the ROM and RAM. It is a bus slave with the same sel/wr_n/a/din/dout contract as the memory devices. Its read data joins the integration's core_data_in mux. It provides a buffered transmitter, a single-byte receive holding register, a programmable bit period and an active-low interrupt request.

---
 rtl/m6809_uart_pkg.sv | 22 ++
 rtl/m6809_sync_fifo.sv | 51 +++++
 rtl/m6809_uart.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/m6809_uart_pkg.sv
// Shared register map, STATUS/CTRL bit positions and serial state encodings
// for the m6809 SoC UART.
package m6809_uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_BAUD   = 2'd3;

    localparam int ST_RXF    = 0;
    localparam int ST_TXNF   = 1;
    localparam int ST_TXIDLE = 2;
    localparam int ST_FE     = 3;
    localparam int ST_OVR    = 4;

    localparam int CTRL_RXIE = 0;
    localparam int CTRL_TXIE = 1;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/m6809_sync_fifo.sv
// Single-clock FIFO; push when full and pop when empty are ignored, and a
// push and pop on the same edge both take effect.
module m6809_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/m6809_uart.sv
// 8N1 UART bus slave for page $FE: buffered transmitter, single-byte receive
// holding register, programmable bit period and registered active-low IRQ.
module m6809_uart
    import m6809_uart_pkg::*;
#(
    parameter int         TX_DEPTH   = 4,
    parameter logic [7:0] BAUD_RESET = 8'd103
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       sel,
    input  logic       wr_n,
    input  logic [1:0] a,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       rxd,
    output logic       txd,
    output logic       irq_b,
    output tx_state_e  tx_state_dbg,
    output rx_state_e  rx_state_dbg
);
    // Bus contract: an access is sel high for exactly one clock; there is no
    // ready/wait, writes and read side effects commit on that edge and dout
    // is valid combinationally within the same cycle.
    logic       wr, rd, data_wr, data_rd;
    logic [1:0] ctrl;
    logic [7:0] baud, rx_hold;
    logic       rxf, fe, ovr;
    logic       fifo_full, fifo_empty, tx_pop;
    logic [7:0] fifo_dout;

    assign wr      = sel & ~wr_n;
    assign rd      = sel & wr_n;
    assign data_wr = wr && (a == REG_DATA);
    assign data_rd = rd && (a == REG_DATA);

    m6809_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset_b (reset_b),
        .push    (data_wr),
        .din     (din),
        .pop     (tx_pop),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    tx_state_e  tx_state, tx_state_d;
    logic [7:0] tx_cnt, tx_cnt_d, tx_shift, tx_shift_d;
    logic [2:0] tx_bit, tx_bit_d;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_shift <= '0;
            tx_bit   <= '0;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_shift <= tx_shift_d;
            tx_bit   <= tx_bit_d;
        end
    end

    // The bit counter reloads from BAUD only at bit boundaries.
    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt;
        tx_shift_d = tx_shift;
        tx_bit_d   = tx_bit;
        tx_pop     = 1'b0;
        if (tx_state == TX_IDLE) begin
            if (!fifo_empty) begin
                tx_pop     = 1'b1;
                tx_shift_d = fifo_dout;
                tx_cnt_d   = baud;
                tx_state_d = TX_START;
            end
        end else if (tx_cnt != 8'd0) begin
            tx_cnt_d = tx_cnt - 8'd1;
        end else begin
            tx_cnt_d = baud;
            case (tx_state)
                TX_START: begin
                    tx_bit_d   = 3'd0;
                    tx_state_d = TX_DATA;
                end
                TX_DATA: begin
                    if (tx_bit == 3'd7) begin
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d   = tx_bit + 3'd1;
                        tx_shift_d = {1'b0, tx_shift[7:1]};
                    end
                end
                default: begin
                    if (!fifo_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = fifo_dout;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        case (tx_state)
            TX_START: txd = 1'b0;
            TX_DATA:  txd = tx_shift[0];
            default:  txd = 1'b1;
        endcase
    end

    rx_state_e  rx_state, rx_state_d;
    logic [1:0] rx_sync;
    logic       rx_s, rx_done;
    logic [7:0] rx_cnt, rx_cnt_d, rx_shift, rx_shift_d;
    logic [2:0] rx_bit, rx_bit_d;

    assign rx_s = rx_sync[1];

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rx_sync  <= 2'b11;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_shift <= '0;
            rx_bit   <= '0;
        end else begin
            rx_sync  <= {rx_sync[0], rxd};
            rx_state <= rx_state_d;
            rx_cnt   <= rx_cnt_d;
            rx_shift <= rx_shift_d;
            rx_bit   <= rx_bit_d;
        end
    end

    // START waits half a period so later samples land mid-bit.
    always_comb begin
        rx_state_d = rx_state;
        rx_cnt_d   = rx_cnt;
        rx_shift_d = rx_shift;
        rx_bit_d   = rx_bit;
        rx_done    = 1'b0;
        if (rx_state == RX_IDLE) begin
            if (!rx_s) begin
                rx_cnt_d   = {1'b0, baud[7:1]};
                rx_state_d = RX_START;
            end
        end else if (rx_cnt != 8'd0) begin
            rx_cnt_d = rx_cnt - 8'd1;
        end else begin
            rx_cnt_d = baud;
            case (rx_state)
                RX_START: begin
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end
                RX_DATA: begin
                    rx_shift_d = {rx_s, rx_shift[7:1]};
                    rx_bit_d   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_d = RX_STOP;
                end
                default: begin
                    rx_done    = 1'b1;
                    rx_state_d = RX_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            ctrl    <= '0;
            baud    <= BAUD_RESET;
            rx_hold <= '0;
            rxf     <= 1'b0;
            fe      <= 1'b0;
            ovr     <= 1'b0;
            irq_b   <= 1'b1;
        end else begin
            if (wr && (a == REG_CTRL)) ctrl <= din[1:0];
            if (wr && (a == REG_BAUD)) baud <= din;
            // A DATA read on the completion edge frees the holding register first.
            if (rx_done && (!rxf || data_rd)) begin
                rx_hold <= rx_shift;
                rxf     <= 1'b1;
                fe      <= ~rx_s;
                ovr     <= 1'b0;
            end else if (rx_done) begin
                ovr <= 1'b1;
            end else if (data_rd) begin
                rxf <= 1'b0;
                fe  <= 1'b0;
                ovr <= 1'b0;
            end
            irq_b <= ~((ctrl[CTRL_RXIE] & rxf) | (ctrl[CTRL_TXIE] & fifo_empty));
        end
    end

    always_comb begin
        dout = 8'h00;
        case (a)
            REG_DATA: dout = rx_hold;
            REG_STATUS: begin
                dout[ST_RXF]    = rxf;
                dout[ST_TXNF]   = ~fifo_full;
                dout[ST_TXIDLE] = fifo_empty & (tx_state == TX_IDLE);
                dout[ST_FE]     = fe;
                dout[ST_OVR]    = ovr;
            end
            REG_CTRL: dout = {6'b0, ctrl};
            default:  dout = baud;
        endcase
    end

    assign tx_state_dbg = tx_state;
    assign rx_state_dbg = rx_state;

endmodule
